alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer side of the ALU interface: accepts compact ALU instructions over a valid/ready handshake and reads operands from a small internal register file.
- Drives `alu_op`, `op1` and `op2` to the external ALU and captures its WIDTH+1-bit result.
- Writes the result back to the register file and presents it on a backpressured result port.
- Sits between fetch/decode and the ALU in the pipelined core.

Parameters:
- WIDTH, 7, operand width; ALU result is WIDTH+1 bits.
- OP_WIDTH, 3, ALU opcode width.
- NREG, 8, register-file entries (index width RIDX = log2(NREG) = 3); r0 reads as zero.
- INSTR_W, OP_WIDTH+3*RIDX+1+WIDTH-RIDX... fixed localparam = OP_WIDTH+2*RIDX+1+WIDTH (17 at defaults).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  instruction valid.
- `in_ready`  out  1  stage can accept an instruction.
- `in_instr`  in  INSTR_W  fields, MSB first: op[OP_WIDTH], rd[RIDX], rs1[RIDX], imm_sel[1], src2[WIDTH].
  - When imm_sel=1, src2 is an immediate.
  - When imm_sel=0, src2[RIDX-1:0] is rs2.
- `alu_op`  out  OP_WIDTH  opcode to ALU.
- `op1`  out  WIDTH  first operand to ALU.
- `op2`  out  WIDTH  second operand to ALU.
- `alu_result`  in  WIDTH+1  combinational ALU result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_rd`  out  RIDX  destination of presented result.
- `res_data`  out  WIDTH+1  presented result.
- `carry_flag`  out  1  bit WIDTH of the most recent retired result.

Behaviour:
- Reset (async, `rst_n`=0): all valids 0, all regfile entries 0, `carry_flag`=0, `res_rd`=0, `res_data`=0, `alu_op`/`op1`/`op2`=0. While `rst_n` is low, `in_ready`=1 is driven. Reset mid-operation discards every in-flight instruction; nothing is written.
- Stages:
  - ID register: holds the accepted instruction, `id_valid`.
  - EX: combinational; drives the ALU from the ID register and the regfile.
  - WB register: holds the result, `res_valid`.
- When `id_valid`=0, `alu_op`/`op1`/`op2` = 0.
- Operands:
  - `op1` = R[rs1].
  - `op2` = imm_sel ? src2 : R[src2[RIDX-1:0]].
  - R[0] = 0 always.
- Advance rules:
  - ex_go = `id_valid` & (!`res_valid` | `res_ready`).
  - `in_ready` = !`id_valid` | ex_go (combinational).
  - Accept when `in_valid` & `in_ready`: ID loads `in_instr`, `id_valid`=1. If ex_go and no accept, `id_valid`=0.
- On ex_go at a clock edge:
  - WB loads `res_data`=`alu_result` and `res_rd`=rd; `res_valid`=1.
  - R[rd] <= `alu_result`[WIDTH-1:0], unless rd=0.
  - `carry_flag` <= `alu_result`[WIDTH]; this includes rd=0.
- If `res_valid` & `res_ready` & !ex_go: `res_valid`=0.
- Latency: instruction accepted at edge N is presented (`res_valid`=1) after edge N+1. Full throughput is 1/cycle with `res_ready`=1.
- RAW hazards: the regfile is written at the EX->WB edge, so the following instruction reads the updated value in its EX cycle. No stall and no bypass are needed.
- Backpressure: while `res_valid` & !`res_ready`, WB holds, ID holds, and no regfile write occurs. `in_ready`=0 once ID is full. Maximum 2 instructions in flight. No loss or duplication; order is preserved.
- Undefined opcodes (000, 110, 111): the ALU returns 0, which is written normally.
- Simultaneous accept and ex_go in the same cycle is legal (pipeline refill).

Optional Feature:
- `ISSUE_STALL_CNT_EN`
  - Defined: adds port `stall_cnt` out 8. It is an 8-bit saturating counter that increments each cycle `res_valid` & !`res_ready`, holds at 255, and resets to 0.
  - Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert `rst_n`=0 mid-stream -> `res_valid`=0, `in_ready`=1, `carry_flag`=0. After release, add r1=r1+imm 0 gives `res_data`=0x00.
- Immediate add: add r1=r0+0x05, then add r2=r1+imm 0x7E back-to-back -> results 0x05 then 0x83; `carry_flag`=1; R2=0x03. Check the 2-cycle latency.
- RAW chain: r1=r0+0x10, then r2=r1+r1 (reg, next cycle), then r3=r2^imm 0x7F -> 0x10, 0x20, 0x5F with no bubbles.
- Subtract borrow and logic: r1=0x03, then sub r4=r1-imm 0x05 -> `res_data`=0xFE, R4=0x7E, `carry_flag`=1. Then and r5=r4&imm 0x0F -> 0x0E, `carry_flag`=0.
- Backpressure: hold `res_ready`=0 for 4 cycles while 3 instructions are offered -> 2 accepted, `in_ready`=0, the first result held stable. Release -> all 3 results emerge in order, no duplicates (`stall_cnt`=4 with `ISSUE_STALL_CNT_EN`).
- r0 and bad opcode: add r0=r0+0x7F -> `res_data`=0x7F, R0 still reads 0. Opcode 111 -> `res_data`=0x00 written to rd.

Source files
------------

// File: rtl/alu_issue_stage.sv
//------------------------------------------------------------------------------
// alu_issue_stage
//
// Issue stage sitting between fetch/decode and an external combinational ALU.
// Instructions are taken over a valid/ready handshake into an ID register.
// Their operands are read from a small register file in the EX step, and the
// ALU result is captured into a WB register. That register is presented on a
// backpressured result port.
//
// Instruction layout, MSB first:
//   op[OP_WIDTH] | rd[RIDX] | rs1[RIDX] | imm_sel | src2[WIDTH]
//   imm_sel=1 : src2 is an immediate
//   imm_sel=0 : src2[RIDX-1:0] names rs2
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      instruction handshake
//   in_instr               instruction word (INSTR_W bits)
//   alu_op, op1, op2       drive the external ALU (all zero when ID is empty)
//   alu_result             combinational ALU result, WIDTH+1 bits
//   res_valid/res_ready    result handshake
//   res_rd, res_data       destination and value of the presented result
//   carry_flag             bit WIDTH of the most recently retired result
//   stall_cnt              (ISSUE_STALL_CNT_EN only) saturating count of
//                          cycles the result was held by backpressure
//
// Optional feature macro: ISSUE_STALL_CNT_EN
//
// Handshake rule: on both ports a transfer happens on a rising edge where
// valid and ready are both high. A valid, once raised, holds with its payload
// stable until that transfer completes.
//------------------------------------------------------------------------------
module alu_issue_stage #(
   parameter  int WIDTH    = 7,
   parameter  int OP_WIDTH = 3,
   parameter  int NREG     = 8,
   localparam int RIDX     = $clog2(NREG),
   localparam int INSTR_W  = OP_WIDTH + 2*RIDX + 1 + WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [INSTR_W-1:0]  in_instr,
   output logic [OP_WIDTH-1:0] alu_op,
   output logic [WIDTH-1:0]    op1,
   output logic [WIDTH-1:0]    op2,
   input  logic [WIDTH:0]      alu_result,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [RIDX-1:0]     res_rd,
   output logic [WIDTH:0]      res_data,
`ifdef ISSUE_STALL_CNT_EN
   output logic [7:0]          stall_cnt,
`endif
   output logic                carry_flag
);

   // ID register
   logic               id_valid;
   logic [INSTR_W-1:0] id_instr;

   // Register file; entry 0 is never written and reads as zero
   logic [WIDTH-1:0] rf [NREG];

   // Decoded ID fields
   logic [OP_WIDTH-1:0] id_op;
   logic [RIDX-1:0]     id_rd;
   logic [RIDX-1:0]     id_rs1;
   logic                id_imm_sel;
   logic [WIDTH-1:0]    id_src2;
   logic [RIDX-1:0]     id_rs2;

   assign id_op      = id_instr[INSTR_W-1 -: OP_WIDTH];
   assign id_rd      = id_instr[INSTR_W-OP_WIDTH-1 -: RIDX];
   assign id_rs1     = id_instr[INSTR_W-OP_WIDTH-RIDX-1 -: RIDX];
   assign id_imm_sel = id_instr[WIDTH];
   assign id_src2    = id_instr[WIDTH-1:0];
   assign id_rs2     = id_src2[RIDX-1:0];

   logic [WIDTH-1:0] rs1_val;
   logic [WIDTH-1:0] rs2_val;

   assign rs1_val = (id_rs1 == '0) ? '0 : rf[id_rs1];
   assign rs2_val = (id_rs2 == '0) ? '0 : rf[id_rs2];

   // Advance control. The regfile is written on the same edge that moves a
   // result into WB, so the next instruction's EX already sees the new value.
   logic ex_go;
   logic accept;

   assign ex_go    = id_valid & (~res_valid | res_ready);
   assign in_ready = ~id_valid | ex_go;
   assign accept   = in_valid & in_ready;

   // EX: drive the ALU only while ID holds an instruction
   always_comb begin
      alu_op = '0;
      op1    = '0;
      op2    = '0;
      if (id_valid) begin
         alu_op = id_op;
         op1    = rs1_val;
         op2    = id_imm_sel ? id_src2 : rs2_val;
      end
   end

   // ID and WB registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid   <= 1'b0;
         id_instr   <= '0;
         res_valid  <= 1'b0;
         res_rd     <= '0;
         res_data   <= '0;
         carry_flag <= 1'b0;
      end else begin
         if (accept) begin
            id_valid <= 1'b1;
            id_instr <= in_instr;
         end else if (ex_go) begin
            id_valid <= 1'b0;
         end

         if (ex_go) begin
            res_valid  <= 1'b1;
            res_rd     <= id_rd;
            res_data   <= alu_result;
            // The carry tracks every retirement, including writes to r0
            carry_flag <= alu_result[WIDTH];
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

   // Register file write at the EX->WB edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (ex_go && (id_rd != '0)) begin
         rf[id_rd] <= alu_result[WIDTH-1:0];
      end
   end

`ifdef ISSUE_STALL_CNT_EN
   // Cycles in which a presented result was refused, saturating at 255
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (res_valid && !res_ready && (stall_cnt != 8'hFF)) begin
         stall_cnt <= stall_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
//------------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage. A small behavioural ALU closes the loop:
// 001 add, 010 sub, 011 and, 100 or, 101 xor; every other opcode returns 0.
// Expected results are hand-computed and queued in issue order. A monitor
// retires them against the result port.
//------------------------------------------------------------------------------
module tb_alu_issue_stage;

   localparam int WIDTH    = 7;
   localparam int OP_WIDTH = 3;
   localparam int RIDX     = 3;
   localparam int INSTR_W  = OP_WIDTH + 2*RIDX + 1 + WIDTH;

   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_BAD = 3'd7;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [INSTR_W-1:0]  in_instr;
   logic [OP_WIDTH-1:0] alu_op;
   logic [WIDTH-1:0]    op1;
   logic [WIDTH-1:0]    op2;
   logic [WIDTH:0]      alu_result;
   logic                res_valid;
   logic                res_ready;
   logic [RIDX-1:0]     res_rd;
   logic [WIDTH:0]      res_data;
   logic                carry_flag;
`ifdef ISSUE_STALL_CNT_EN
   logic [7:0]          stall_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic [RIDX+WIDTH:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   alu_issue_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .alu_op     (alu_op),
      .op1        (op1),
      .op2        (op2),
      .alu_result (alu_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_rd     (res_rd),
      .res_data   (res_data),
`ifdef ISSUE_STALL_CNT_EN
      .stall_cnt  (stall_cnt),
`endif
      .carry_flag (carry_flag)
   );

   // Behavioural ALU
   always_comb begin
      case (alu_op)
         OP_ADD:  alu_result = {1'b0, op1} + {1'b0, op2};
         OP_SUB:  alu_result = {1'b0, op1} - {1'b0, op2};
         OP_AND:  alu_result = {1'b0, op1 & op2};
         OP_OR:   alu_result = {1'b0, op1 | op2};
         OP_XOR:  alu_result = {1'b0, op1 ^ op2};
         default: alu_result = '0;
      endcase
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                             input logic [2:0] rs1, input logic isel,
                                             input logic [6:0] src2);
      return {op, rd, rs1, isel, src2};
   endfunction

   // Entered and left just after a rising edge; returns once the edge that
   // accepts the instruction has passed.
   task automatic send(input logic [INSTR_W-1:0] ins, input logic [WIDTH:0] exp_data);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_instr = ins;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
      else exp_q.push_back({ins[INSTR_W-OP_WIDTH-1 -: RIDX], exp_data});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (exp_q.size() == 0) check("extra_result", 32'(res_valid), 32'd0);
         else check("result", 32'({res_rd, res_data}), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_carry", 32'(carry_flag), 32'd0);
      check("rst_res", 32'({res_rd, res_data}), 32'd0);
      check("rst_alu_drive", 32'({alu_op, op1, op2}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset in the middle of traffic
      send(mk(OP_SUB, 3'd1, 3'd0, 1'b1, 7'h01), 8'hFF);
      drain();
      check("borrow_carry", 32'(carry_flag), 32'd1);
      res_ready = 1'b0;
      send(mk(OP_ADD, 3'd2, 3'd0, 1'b1, 7'h05), 8'h05);
      send(mk(OP_ADD, 3'd3, 3'd0, 1'b1, 7'h06), 8'h06);
      check("full_in_ready", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_res_valid", 32'(res_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_carry", 32'(carry_flag), 32'd0);
      exp_q.delete();
      res_ready = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(mk(OP_ADD, 3'd1, 3'd1, 1'b1, 7'h00), 8'h00);
      drain();

      // Immediate add, two-cycle latency, carry out
      check("idle_res_valid", 32'(res_valid), 32'd0);
      send(mk(OP_ADD, 3'd1, 3'd0, 1'b1, 7'h05), 8'h05);
      check("lat_not_yet", 32'(res_valid), 32'd0);
      send(mk(OP_ADD, 3'd2, 3'd1, 1'b1, 7'h7E), 8'h83);
      check("lat_present", 32'(res_valid), 32'd1);
      check("lat_data", 32'(res_data), 32'h05);
      @(posedge clk);
      #1;
      check("add_carry_data", 32'(res_data), 32'h83);
      check("add_carry_flag", 32'(carry_flag), 32'd1);
      send(mk(OP_ADD, 3'd7, 3'd2, 1'b1, 7'h00), 8'h03);
      drain();

      // RAW chain, back to back
      send(mk(OP_ADD, 3'd1, 3'd0, 1'b1, 7'h10), 8'h10);
      send(mk(OP_ADD, 3'd2, 3'd1, 1'b0, 7'h01), 8'h20);
      send(mk(OP_XOR, 3'd3, 3'd2, 1'b1, 7'h7F), 8'h5F);
      check("raw_valid", 32'(res_valid), 32'd1);
      check("raw_second", 32'(res_data), 32'h20);
      @(posedge clk);
      #1;
      check("raw_third", 32'(res_data), 32'h5F);
      drain();

      // Subtract with borrow, then logic clears the carry
      send(mk(OP_ADD, 3'd1, 3'd0, 1'b1, 7'h03), 8'h03);
      send(mk(OP_SUB, 3'd4, 3'd1, 1'b1, 7'h05), 8'hFE);
      send(mk(OP_AND, 3'd5, 3'd4, 1'b1, 7'h0F), 8'h0E);
      check("sub_data", 32'(res_data), 32'hFE);
      check("sub_carry", 32'(carry_flag), 32'd1);
      @(posedge clk);
      #1;
      check("and_data", 32'(res_data), 32'h0E);
      check("and_carry", 32'(carry_flag), 32'd0);
      send(mk(OP_ADD, 3'd6, 3'd4, 1'b1, 7'h00), 8'h7E);
      drain();

      // Backpressure: three offered while the result port is stalled
      res_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = mk(OP_OR, 3'd1, 3'd0, 1'b1, 7'h2A);
      exp_q.push_back({3'd1, 8'h2A});
      @(posedge clk);
      #1;
      check("bp_ready_one", 32'(in_ready), 32'd1);
      in_instr = mk(OP_ADD, 3'd2, 3'd1, 1'b1, 7'h01);
      exp_q.push_back({3'd2, 8'h2B});
      @(posedge clk);
      #1;
      in_instr = mk(OP_XOR, 3'd3, 3'd2, 1'b1, 7'h01);
      check("bp_full", 32'(in_ready), 32'd0);
      check("bp_first", 32'({res_valid, res_rd, res_data}), 32'({1'b1, 3'd1, 8'h2A}));
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check("bp_hold_ready", 32'(in_ready), 32'd0);
         check("bp_hold_res", 32'({res_valid, res_rd, res_data}), 32'({1'b1, 3'd1, 8'h2A}));
      end
`ifdef ISSUE_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'd4);
`endif
      res_ready = 1'b1;
      exp_q.push_back({3'd3, 8'h2A});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_second", 32'({res_rd, res_data}), 32'({3'd2, 8'h2B}));
      drain();

      // r0 stays zero, carry still follows rd=0, undefined opcode writes 0
      send(mk(OP_ADD, 3'd0, 3'd0, 1'b1, 7'h7F), 8'h7F);
      send(mk(OP_ADD, 3'd7, 3'd0, 1'b0, 7'h00), 8'h00);
      send(mk(OP_ADD, 3'd0, 3'd1, 1'b1, 7'h7F), 8'hA9);
      drain();
      check("carry_rd0", 32'(carry_flag), 32'd1);
      send(mk(OP_BAD, 3'd6, 3'd1, 1'b1, 7'h05), 8'h00);
      send(mk(OP_ADD, 3'd7, 3'd6, 1'b1, 7'h01), 8'h01);
      drain();

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
